// File: rtl/sqrt_sched_if.sv
// rtl/sqrt_sched_if.sv - request/result bundle for the shared square-root scheduler
//
// Purpose: groups the requester handshake and the result bus of sqrt_sched.
// Signals:
//   req          [NREQ]     request per channel, held with datain stable until ack
//   datain       [NREQ*64]  operands, channel i at [64*i+63:64*i]
//   ack          [NREQ]     one-hot 1-cycle grant pulse
//   busy                    high while the engine is iterating
//   pushout                 1-cycle result-valid pulse
//   tagout       [TAGW]     requester index owning the result
//   rootout      [32]       square root (floor, or rounded when SQRT_ROUND_EN)
//   remainderout [33]       x - floor_root^2
//   squareout    [64]       original operand
// Modports: master = requester/consumer side, slave = scheduler side.
interface sqrt_sched_if #(
   parameter int NREQ = 4,
   parameter int TAGW = 2
);
   logic [NREQ-1:0]    req;
   logic [NREQ*64-1:0] datain;
   logic [NREQ-1:0]    ack;
   logic               busy;
   logic               pushout;
   logic [TAGW-1:0]    tagout;
   logic [31:0]        rootout;
   logic [32:0]        remainderout;
   logic [63:0]        squareout;

   modport master (
      output req, datain,
      input  ack, busy, pushout, tagout, rootout, remainderout, squareout
   );

   modport slave (
      input  req, datain,
      output ack, busy, pushout, tagout, rootout, remainderout, squareout
   );
endinterface

// File: rtl/sqrt_sched.sv
// rtl/sqrt_sched.sv - round-robin shared iterative 64-bit integer square-root engine
//
// Purpose: one restoring 2-bits-per-step square-root engine shared by NREQ
// requesters. One operation in flight; SPC recurrence steps per clock, so an
// operation takes N = 32/SPC run cycles after its grant.
// Ports:
//   clk_i   clock, all logic on posedge
//   rst_i   synchronous active-high reset
//   bus     sqrt_sched_if.slave (req/datain in; ack/busy/pushout/tagout/
//           rootout/remainderout/squareout out, all registered)
// Configuration macro: SQRT_ROUND_EN - rootout rounded to nearest (saturating);
// when undefined rootout is the floor root and no rounding logic exists.
module sqrt_sched #(
   parameter int NREQ = 4,
   parameter int TAGW = 2,
   parameter int SPC  = 1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   sqrt_sched_if.slave bus
);
   localparam int N  = 32 / SPC;
   localparam int CW = 6;

   typedef enum logic {IDLE, RUN} state_t;

   state_t          state_q;
   logic [TAGW-1:0] ptr_q;
   logic [TAGW-1:0] tag_q;
   logic [63:0]     x_q;
   logic [63:0]     sq_q;
   logic [31:0]     root_q;
   logic [33:0]     rem_q;
   logic [CW-1:0]   cnt_q;

   logic [NREQ-1:0] ack_q;
   logic            busy_q;
   logic            push_q;
   logic [TAGW-1:0] tagout_q;
   logic [31:0]     rootout_q;
   logic [32:0]     remout_q;
   logic [63:0]     sqout_q;

   logic [63:0]     x_d;
   logic [31:0]     root_d;
   logic [33:0]     rem_d;
   logic [33:0]     rem_t;
   logic [33:0]     trial;
   logic [31:0]     root_fin;

   logic            win_vld;
   logic [TAGW-1:0] win_idx;

   // Round-robin search starts just after the last winner and wraps.
   always_comb begin
      win_vld = 1'b0;
      win_idx = ptr_q;
      for (int k = 1; k <= NREQ; k++) begin
         if (!win_vld && bus.req[(int'(ptr_q) + k) % NREQ]) begin
            win_vld = 1'b1;
            win_idx = TAGW'((int'(ptr_q) + k) % NREQ);
         end
      end
   end

   // SPC restoring steps chained combinationally. rem never exceeds 2*root,
   // so the shifted partial remainder always fits in 34 bits.
   always_comb begin
      x_d    = x_q;
      root_d = root_q;
      rem_d  = rem_q;
      rem_t  = '0;
      trial  = '0;
      for (int s = 0; s < SPC; s++) begin
         rem_t = (rem_d << 2) | {32'd0, x_d[63:62]};
         trial = {root_d, 2'b01};
         x_d   = {x_d[61:0], 2'b00};
         if (trial <= rem_t) begin
            rem_d  = rem_t - trial;
            root_d = {root_d[30:0], 1'b1};
         end else begin
            rem_d  = rem_t;
            root_d = {root_d[30:0], 1'b0};
         end
      end
   end

`ifdef SQRT_ROUND_EN
   // x lies past the midpoint (r+0.5)^2 exactly when rem > r; hold at all-ones.
   always_comb begin
      root_fin = root_d;
      if (rem_d > {2'b00, root_d} && root_d != 32'hFFFF_FFFF) begin
         root_fin = root_d + 32'd1;
      end
   end
`else
   assign root_fin = root_d;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         ptr_q     <= TAGW'(NREQ - 1);
         tag_q     <= '0;
         x_q       <= '0;
         sq_q      <= '0;
         root_q    <= '0;
         rem_q     <= '0;
         cnt_q     <= '0;
         ack_q     <= '0;
         busy_q    <= 1'b0;
         push_q    <= 1'b0;
         tagout_q  <= '0;
         rootout_q <= '0;
         remout_q  <= '0;
         sqout_q   <= '0;
      end else begin
         ack_q  <= '0;
         push_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (win_vld) begin
                  x_q     <= bus.datain[int'(win_idx)*64 +: 64];
                  sq_q    <= bus.datain[int'(win_idx)*64 +: 64];
                  tag_q   <= win_idx;
                  ptr_q   <= win_idx;
                  ack_q   <= NREQ'(1) << win_idx;
                  root_q  <= '0;
                  rem_q   <= '0;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end
            end
            RUN: begin
               x_q    <= x_d;
               root_q <= root_d;
               rem_q  <= rem_d;
               cnt_q  <= cnt_q + CW'(1);
               if (cnt_q == CW'(N - 1)) begin
                  push_q    <= 1'b1;
                  tagout_q  <= tag_q;
                  rootout_q <= root_fin;
                  remout_q  <= rem_d[32:0];
                  sqout_q   <= sq_q;
                  busy_q    <= 1'b0;
                  state_q   <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.ack          = ack_q;
   assign bus.busy         = busy_q;
   assign bus.pushout      = push_q;
   assign bus.tagout       = tagout_q;
   assign bus.rootout      = rootout_q;
   assign bus.remainderout = remout_q;
   assign bus.squareout    = sqout_q;
endmodule

// File: tb/tb_sqrt_sched.sv
// tb/tb_sqrt_sched.sv - randomized self-checking bench for sqrt_sched at SPC=1,2,4
module tb_sqrt_sched;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk  = 0;
   int n_pass = 0;

`ifdef SQRT_ROUND_EN
   localparam bit ROUND = 1'b1;
`else
   localparam bit ROUND = 1'b0;
`endif

   logic [3:0]   req_a  [3];
   logic [255:0] data_a [3];
   logic         rst_a  [3];
   logic [3:0]   ack_w  [3];
   logic         busy_w [3];
   logic         push_w [3];
   logic [1:0]   tag_w  [3];
   logic [31:0]  root_w [3];
   logic [32:0]  rem_w  [3];
   logic [63:0]  sq_w   [3];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      sqrt_sched_if #(.NREQ(4), .TAGW(2)) u_if ();
      assign u_if.req    = req_a[g];
      assign u_if.datain = data_a[g];
      assign ack_w[g]    = u_if.ack;
      assign busy_w[g]   = u_if.busy;
      assign push_w[g]   = u_if.pushout;
      assign tag_w[g]    = u_if.tagout;
      assign root_w[g]   = u_if.rootout;
      assign rem_w[g]    = u_if.remainderout;
      assign sq_w[g]     = u_if.squareout;
      sqrt_sched #(.NREQ(4), .TAGW(2), .SPC(1 << g)) u_dut (
         .clk_i (clk),
         .rst_i (rst_a[g]),
         .bus   (u_if)
      );
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   function automatic int nlat(input int d);
      return 32 >> d;
   endfunction

   // Reference: bitwise search for the largest r with r*r <= x.
   function automatic logic [31:0] isqrt(input logic [63:0] x);
      logic [31:0] r = '0;
      logic [31:0] c;
      for (int b = 31; b >= 0; b--) begin
         c = r | (32'd1 << b);
         if ({32'd0, c} * {32'd0, c} <= x) r = c;
      end
      return r;
   endfunction

   function automatic logic [32:0] rem_of(input logic [63:0] x);
      logic [31:0] r = isqrt(x);
      return 33'(x - {32'd0, r} * {32'd0, r});
   endfunction

   function automatic logic [31:0] exp_root(input logic [63:0] x);
      logic [31:0] r = isqrt(x);
      if (ROUND && {31'd0, rem_of(x)} > {32'd0, r} && r != 32'hFFFF_FFFF) return r + 32'd1;
      return r;
   endfunction

   task automatic wait_ack(input int d, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         ok = (ack_w[d] != 4'd0);
      end
   endtask

   task automatic wait_push(input int d, output bit ok, output int lat);
      ok  = 1'b0;
      lat = 0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         lat++;
         ok = push_w[d];
      end
   endtask

   task automatic do_reset(input int d);
      rst_a[d] = 1'b1;
      req_a[d] = 4'd0;
      @(negedge clk);
      rst_a[d] = 1'b0;
   endtask

   task automatic check_zero(input int d, input string name);
      check({name, "_ack"},  64'(ack_w[d]), 64'd0);
      check({name, "_busy"}, 64'(busy_w[d]), 64'd0);
      check({name, "_push"}, 64'(push_w[d]), 64'd0);
      check({name, "_tag"},  64'(tag_w[d]), 64'd0);
      check({name, "_root"}, 64'(root_w[d]), 64'd0);
      check({name, "_rem"},  64'(rem_w[d]), 64'd0);
      check({name, "_sq"},   sq_w[d], 64'd0);
   endtask

   task automatic do_op(input int d, input int ch, input logic [63:0] x,
                        input logic [31:0] eroot, input logic [32:0] erem, input string name);
      bit ok;
      int lat;
      req_a[d] = 4'(1 << ch);
      data_a[d][64*ch +: 64] = x;
      wait_ack(d, ok);
      req_a[d] = 4'd0;
      check({name, "_ack_seen"}, 64'(ok), 64'd1);
      if (ok) begin
         check({name, "_ack"},  64'(ack_w[d]), 64'(1 << ch));
         check({name, "_busy"}, 64'(busy_w[d]), 64'd1);
         wait_push(d, ok, lat);
         check({name, "_push_seen"}, 64'(ok), 64'd1);
         if (ok) begin
            check({name, "_lat"},  64'(lat), 64'(nlat(d)));
            check({name, "_tag"},  64'(tag_w[d]), 64'(ch));
            check({name, "_root"}, 64'(root_w[d]), 64'(eroot));
            check({name, "_rem"},  64'(rem_w[d]), 64'(erem));
            check({name, "_sq"},   sq_w[d], x);
         end
      end
   endtask

   task automatic rand_run(input int d, input int count);
      logic [63:0] x;
      logic [31:0] y;
      int ch;
      for (int k = 0; k < count; k++) begin
         ch = $urandom_range(3, 0);
         case ($urandom_range(4, 0))
            0: x = {32'd0, $urandom};
            1: x = 64'($urandom_range(1000, 0));
            2: begin y = $urandom; x = {32'd0, y} * {32'd0, y}; end
            3: x = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(3, 0));
            default: x = {$urandom, $urandom};
         endcase
         do_op(d, ch, x, exp_root(x), rem_of(x), "rnd");
      end
   endtask

   task automatic directed();
      logic [63:0] xs [4];
      bit ok;
      int lat, prev, npush;
      do_op(0, 0, 64'd0, 32'd0, 33'd0, "zero");
      do_op(0, 2, 64'd1000000, 32'd1000, 33'd0, "x1e6");
      do_op(0, 2, 64'd99, ROUND ? 32'd10 : 32'd9, 33'd18, "x99");
      do_op(0, 2, 64'd90, 32'd9, 33'd9, "x90");
      do_op(0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 33'h1_FFFF_FFFE, "xmax");

      // All four requesting continuously: grant order 0,1,2,3,0 every N+1 cycles.
      do_reset(0);
      for (int c = 0; c < 4; c++) begin
         xs[c] = {$urandom, $urandom};
         data_a[0][64*c +: 64] = xs[c];
      end
      req_a[0] = 4'hF;
      prev = 0;
      for (int i = 0; i < 5; i++) begin
         wait_ack(0, ok);
         check("rr_ack_seen", 64'(ok), 64'd1);
         if (i == 4) req_a[0] = 4'd0;
         check("rr_ack", 64'(ack_w[0]), 64'(1 << (i % 4)));
         if (i > 0) check("rr_spacing", 64'(cyc - prev), 64'(nlat(0) + 1));
         prev = cyc;
         wait_push(0, ok, lat);
         check("rr_push_seen", 64'(ok), 64'd1);
         check("rr_tag",  64'(tag_w[0]), 64'(i % 4));
         check("rr_sq",   sq_w[0], xs[i % 4]);
         check("rr_root", 64'(root_w[0]), 64'(exp_root(xs[i % 4])));
      end

      // Reset in the middle of an operation discards it.
      req_a[0] = 4'b0001;
      data_a[0][63:0] = 64'd123456789;
      wait_ack(0, ok);
      req_a[0] = 4'd0;
      check("mid_ack_seen", 64'(ok), 64'd1);
      repeat (10) @(negedge clk);
      rst_a[0] = 1'b1;
      @(negedge clk);
      rst_a[0] = 1'b0;
      check_zero(0, "midrst");
      npush = 0;
      repeat (40) begin
         @(negedge clk);
         if (push_w[0]) npush++;
      end
      check("midrst_no_push", 64'(npush), 64'd0);
      req_a[0] = 4'b1010;
      data_a[0][64*1 +: 64] = 64'd1000000;
      data_a[0][64*3 +: 64] = 64'd49;
      wait_ack(0, ok);
      req_a[0] = 4'd0;
      check("post_rst_ack", 64'(ack_w[0]), 64'b0010);
      wait_push(0, ok, lat);
      check("post_rst_tag",  64'(tag_w[0]), 64'd1);
      check("post_rst_root", 64'(root_w[0]), 64'd1000);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int d = 0; d < 3; d++) begin
         req_a[d]  = 4'd0;
         data_a[d] = '0;
         rst_a[d]  = 1'b1;
      end
      repeat (3) @(negedge clk);
      for (int d = 0; d < 3; d++) rst_a[d] = 1'b0;
      check_zero(0, "reset");
      check_zero(2, "reset4");
      fork
         begin
            directed();
            rand_run(0, 1000);
         end
         rand_run(1, 1000);
         rand_run(2, 1000);
      join
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
